ff10_reg: RTL and testbench

//  Behavioural register bank standing in for the transistor-level 10-bit flip-flop (ff10) in digital sims.

---
 rtl/ff10_reg.sv | 110 +++++++++++
 tb/tb_ff10_reg.sv | 119 +++++++++++
 2 files changed

// File: rtl/ff10_reg.sv
// ff10_reg: behavioural stand-in for the transistor-level 10-bit flip-flop.
// Each bit has its own rise/fall latency in clock edges, counted by a 3-bit
// counter. A D pulse that is shorter than the latency does not reach Q.
// Optional feature macro: FF10_TOGGLE_CNT_EN enables the saturating
// Q-transition counter on TOG_CNT. When the macro is not defined, TOG_CNT is 0.
module ff10_reg #(
  parameter int              WIDTH    = 10,
  parameter int              RISE_LAT = 1,
  parameter int              FALL_LAT = 2,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             CK,
  input  logic             RST,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic             SETTLED,
  output logic [15:0]      TOG_CNT
);

  // Stop elaboration when a parameter is outside its legal range.
  if (WIDTH < 1) begin : g_bad_width
    $error("ff10_reg: WIDTH must be >= 1");
  end
  if (RISE_LAT < 1 || RISE_LAT > 8) begin : g_bad_rise
    $error("ff10_reg: RISE_LAT must be in 1..8");
  end
  if (FALL_LAT < 1 || FALL_LAT > 8) begin : g_bad_fall
    $error("ff10_reg: FALL_LAT must be in 1..8");
  end

  // The 3-bit counter plus one can reach 8, so the comparison uses 4 bits.
  localparam logic [3:0] RISE_L = 4'(RISE_LAT);
  localparam logic [3:0] FALL_L = 4'(FALL_LAT);

  logic [WIDTH-1:0] q_reg;
  logic [WIDTH-1:0] q_next;
  logic             settled_reg;

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
    logic [2:0] cnt_reg;
    logic [2:0] cnt_next;
    logic       q_bit_next;
    logic [3:0] lat;

    // Per-bit inertial filter. Q follows D only after D has held a new
    // value for lat consecutive edges. If D returns to Q, the pending change is dropped.
    always_comb begin
      cnt_next   = 3'd0;
      q_bit_next = q_reg[gi];
      lat        = D[gi] ? RISE_L : FALL_L;
      if (D[gi] != q_reg[gi]) begin
        if ({1'b0, cnt_reg} + 4'd1 >= lat) begin
          q_bit_next = D[gi];
        end else begin
          cnt_next = cnt_reg + 3'd1;
        end
      end
    end

    // Pending-edge counter. Reset clears it even when a change is in progress.
    always_ff @(posedge CK) begin
      if (RST) cnt_reg <= 3'd0;
      else     cnt_reg <= cnt_next;
    end

    assign q_next[gi] = q_bit_next;
  end

  // Output register and settled flag. Both come from the next-state logic,
  // so no path from D to an output is combinational.
  always_ff @(posedge CK) begin
    if (RST) begin
      q_reg       <= RST_VAL;
      settled_reg <= 1'b1;
    end else begin
      q_reg       <= q_next;
      settled_reg <= (q_next == D);
    end
  end

  assign Q       = q_reg;
  assign SETTLED = settled_reg;

`ifdef FF10_TOGGLE_CNT_EN
  logic [15:0] tog_reg;
  logic [15:0] tog_inc;
  logic [16:0] tog_sum;

  // Count the Q bits that flip on this edge, then add that number to the saturating total.
  always_comb begin
    tog_inc = 16'd0;
    for (int k = 0; k < WIDTH; k++) begin
      tog_inc = tog_inc + 16'(q_reg[k] ^ q_next[k]);
    end
    tog_sum = {1'b0, tog_reg} + {1'b0, tog_inc};
  end

  // The switching-energy counter stops at 16'hFFFF and never wraps.
  always_ff @(posedge CK) begin
    if (RST)          tog_reg <= 16'd0;
    else if (tog_sum[16]) tog_reg <= 16'hFFFF;
    else              tog_reg <= tog_sum[15:0];
  end

  assign TOG_CNT = tog_reg;
`else
  assign TOG_CNT = 16'h0000;
`endif

endmodule

// File: tb/tb_ff10_reg.sv
// tb_ff10_reg: table-driven, scoreboard-checked bench for ff10_reg
// (WIDTH=10, RISE_LAT=1, FALL_LAT=2, RST_VAL=0).
// The expected TOG_CNT depends on whether FF10_TOGGLE_CNT_EN is defined.
module tb_ff10_reg;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  d;
  logic [9:0]  q;
  logic        settled;
  logic [15:0] tog_cnt;

  ff10_reg #(.WIDTH(10), .RISE_LAT(1), .FALL_LAT(2), .RST_VAL(10'h000)) dut (
    .CK(clk), .RST(rst), .D(d), .Q(q), .SETTLED(settled), .TOG_CNT(tog_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [9:0] d;
    logic [9:0] q;
    logic       s;
    int         t;
  } vec_t;

  typedef struct {
    logic [9:0]  q;
    logic        s;
    logic [15:0] t;
  } exp_t;

  vec_t tbl [20];
  exp_t sb [$];
  int   n_vec = 0;
  int   n_bad = 0;

  function automatic logic [15:0] exp_tog(input int v);
`ifdef FF10_TOGGLE_CNT_EN
    return (v > 65535) ? 16'hFFFF : 16'(v);
`else
    return 16'h0000;
`endif
  endfunction

  // Drive one edge's inputs, push the expectation, then check the result after the edge.
  task automatic step(input string name, input logic r, input logic [9:0] dv,
                      input logic [9:0] eq, input logic es, input int et);
    exp_t e;
    @(negedge clk);
    rst = r;
    d   = dv;
    sb.push_back('{eq, es, exp_tog(et)});
    @(posedge clk);
    #1;
    e = sb.pop_front();
    n_vec++;
    if (q !== e.q || settled !== e.s || tog_cnt !== e.t) begin
      n_bad++;
      $display("FAIL %s: got Q=%h SETTLED=%b TOG_CNT=%h, want Q=%h SETTLED=%b TOG_CNT=%h",
               name, q, settled, tog_cnt, e.q, e.s, e.t);
    end else begin
      $display("ok   %s: Q=%h SETTLED=%b TOG_CNT=%h", name, q, settled, tog_cnt);
    end
  endtask

  initial begin
    int tog;
    rst = 1'b1;
    d   = 10'h3FF;

    // reset (D ignored)
    tbl[0]  = '{1'b1, 10'h3FF, 10'h000, 1'b1, 0};
    tbl[1]  = '{1'b1, 10'h3FF, 10'h000, 1'b1, 0};
    // rise: latency 1
    tbl[2]  = '{1'b0, 10'h3FF, 10'h3FF, 1'b1, 10};
    tbl[3]  = '{1'b0, 10'h3FF, 10'h3FF, 1'b1, 10};
    // fall: latency 2
    tbl[4]  = '{1'b0, 10'h000, 10'h3FF, 1'b0, 10};
    tbl[5]  = '{1'b0, 10'h000, 10'h000, 1'b1, 20};
    tbl[6]  = '{1'b0, 10'h3FF, 10'h3FF, 1'b1, 30};
    // glitch absorbed; a second glitch shows that the count restarted
    tbl[7]  = '{1'b0, 10'h3FE, 10'h3FF, 1'b0, 30};
    tbl[8]  = '{1'b0, 10'h3FF, 10'h3FF, 1'b1, 30};
    tbl[9]  = '{1'b0, 10'h3FE, 10'h3FF, 1'b0, 30};
    tbl[10] = '{1'b0, 10'h3FF, 10'h3FF, 1'b1, 30};
    // move to 0F0, then mixed direction toward 00F
    tbl[11] = '{1'b0, 10'h0F0, 10'h3FF, 1'b0, 30};
    tbl[12] = '{1'b0, 10'h0F0, 10'h0F0, 1'b1, 36};
    tbl[13] = '{1'b0, 10'h00F, 10'h0FF, 1'b0, 40};
    tbl[14] = '{1'b0, 10'h00F, 10'h00F, 1'b1, 44};
    // reset during a pending fall, then normal timing afterwards
    tbl[15] = '{1'b0, 10'h000, 10'h00F, 1'b0, 44};
    tbl[16] = '{1'b1, 10'h000, 10'h000, 1'b1, 0};
    tbl[17] = '{1'b0, 10'h00F, 10'h00F, 1'b1, 4};
    tbl[18] = '{1'b0, 10'h000, 10'h00F, 1'b0, 4};
    tbl[19] = '{1'b0, 10'h000, 10'h000, 1'b1, 8};

    for (int i = 0; i < 20; i++) begin
      step($sformatf("vec%0d", i), tbl[i].rst, tbl[i].d, tbl[i].q, tbl[i].s, tbl[i].t);
    end

    // Saturation: each cycle of 1 rise edge plus 2 fall edges makes 20 transitions.
    tog = 8;
    for (int i = 0; i < 3300; i++) begin
      tog += 10;
      step("sat_rise", 1'b0, 10'h3FF, 10'h3FF, 1'b1, tog);
      step("sat_fall1", 1'b0, 10'h000, 10'h3FF, 1'b0, tog);
      tog += 10;
      step("sat_fall2", 1'b0, 10'h000, 10'h000, 1'b1, tog);
    end
    step("sat_hold", 1'b0, 10'h3FF, 10'h3FF, 1'b1, 70000);
    step("sat_rst", 1'b1, 10'h3FF, 10'h000, 1'b1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
